// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin; otherwise fixed priority to requester 0 with burst limit.
module alu_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [63:0] req_a_i,
    input  logic [63:0] req_b_i,
    input  logic [9:0]  req_op_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_flag_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_op_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_flag_i
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  op_q;
    logic        owner_q;
    logic [31:0] result_q;
    logic        flag_q;
    logic [1:0]  rsp_valid_q;
    logic        grant_sel;
    logic        accept;

    assign accept = (state_q == StIdle) && (|req_valid_i);

`ifdef ALU_ARB_RR_EN
    // Last granted requester; resets to 1 so requester 0 wins the first contention.
    logic last_q;

    always_comb begin
        grant_sel = 1'b0;
        case (req_valid_i)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_q;
            default: grant_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant_sel;
        end
    end
`else
    localparam int unsigned CntW = $clog2(MAX_BURST + 2);

    logic [CntW-1:0] burst_q;

    always_comb begin
        grant_sel = req_valid_i[1] & (~req_valid_i[0] | (burst_q == CntW'(MAX_BURST)));
    end

    // Counts back-to-back requester-0 wins taken while requester 1 was waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_q <= '0;
        end else if (accept) begin
            if (grant_sel || !req_valid_i[1]) begin
                burst_q <= '0;
            end else begin
                burst_q <= burst_q + CntW'(1);
            end
        end
    end
`endif

    assign req_ready_o  = (accept && !rst_i) ? {grant_sel, ~grant_sel} : 2'b00;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = result_q;
    assign rsp_flag_o   = flag_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_op_o     = op_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            owner_q     <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= grant_sel ? req_a_i[63:32] : req_a_i[31:0];
                        b_q     <= grant_sel ? req_b_i[63:32] : req_b_i[31:0];
                        op_q    <= grant_sel ? req_op_i[9:5] : req_op_i[4:0];
                        owner_q <= grant_sel;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    result_q    <= alu_result_i;
                    flag_q      <= alu_flag_i;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i[owner_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random ops against a reference model.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;

    localparam int unsigned MaxBurst = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_flag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_flag;

    logic [31:0] a_in  [2];
    logic [31:0] b_in  [2];
    logic [4:0]  op_in [2];

    int checks = 0;
    int errors = 0;
    int last_grant = 1;
    int streak = 0;

`ifdef ALU_ARB_RR_EN
    localparam int NOrd = 4;
    int exp_order [NOrd] = '{0, 1, 0, 1};
`else
    localparam int NOrd = 6;
    int exp_order [NOrd] = '{0, 0, 0, 0, 1, 0};
`endif

    assign req_a  = {a_in[1], a_in[0]};
    assign req_b  = {b_in[1], b_in[0]};
    assign req_op = {op_in[1], op_in[0]};

    alu_arbiter #(.MAX_BURST(MaxBurst)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_flag_o   (rsp_flag),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .alu_flag_i   (alu_flag)
    );

    // External ALU: 0 ADD, 1 SUB, 28 signed less-than (flag only), anything else XOR.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
        case (op)
            5'd0:     return {1'b0, a + b};
            5'd1:     return {1'b0, a - b};
            5'b11100: return {($signed(a) < $signed(b)), 32'd0};
            default:  return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb {alu_flag, alu_result} = alu_ref(alu_a, alu_b, alu_op);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_ARB_RR_EN
        return (last_grant == 0) ? 1 : 0;
`else
        return (streak >= int'(MaxBurst)) ? 1 : 0;
`endif
    endfunction

    task automatic model_accept(input logic [1:0] v, input int g);
        last_grant = g;
        if (g == 1 || !v[1]) streak = 0;
        else streak++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op);
        a_in[k]  = a;
        b_in[k]  = b;
        op_in[k] = op;
    endtask

    // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [1:0] v, input int delay, output int g);
        logic [32:0] exp;
        logic [1:0]  oh;
        logic [4:0]  op_exp;
        req_valid = v;
        rsp_ready = 2'b00;
        #1;
        g      = model_grant(v);
        oh     = (g == 1) ? 2'b10 : 2'b01;
        exp    = alu_ref(a_in[g], b_in[g], op_in[g]);
        op_exp = op_in[g];
        check("grant", 64'(req_ready), 64'(oh));
        model_accept(v, g);
        @(negedge clk);
        check("exec_ready", 64'(req_ready), 64'(0));
        check("exec_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        for (int i = 0; i <= delay; i++) begin
            check("rsp_valid", 64'(rsp_valid), 64'(oh));
            check("rsp_result", 64'(rsp_result), 64'(exp[31:0]));
            check("rsp_flag", 64'(rsp_flag), 64'(exp[32]));
            check("resp_ready", 64'(req_ready), 64'(0));
            check("alu_op_hold", 64'(alu_op), 64'(op_exp));
            rsp_ready = (i == delay) ? oh : ~oh;
            @(negedge clk);
        end
        rsp_ready = 2'b00;
        check("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_alu_op", 64'(alu_op), 64'(0));
        check("rst_alu_a", 64'(alu_a), 64'(0));
        check("rst_rsp_result", 64'(rsp_result), 64'(0));
        rst        = 1'b0;
        req_valid  = 2'b00;
        rsp_ready  = 2'b00;
        last_grant = 1;
        streak     = 0;
        @(negedge clk);
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        set_req(0, 32'd0, 32'd0, 5'd0);
        set_req(1, 32'd0, 32'd0, 5'd0);
        do_reset();

        // Single ADD from requester 0.
        set_req(0, 32'd7, 32'd5, 5'd0);
        run_op(2'b01, 0, g);
        check("add_owner", 64'(g), 64'(0));

        // Signed compare from requester 1.
        set_req(1, 32'hFFFF_FFFF, 32'd1, 5'b11100);
        run_op(2'b10, 0, g);
        check("lts_owner", 64'(g), 64'(1));

        // A request withdrawn before the edge is never accepted.
        req_valid = 2'b10;
        #1;
        check("drop_ready", 64'(req_ready), 64'(2'b10));
        #2;
        req_valid = 2'b00;
        @(negedge clk);
        check("drop_no_accept_ready", 64'(req_ready), 64'(0));
        check("drop_no_rsp", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("drop_no_rsp2", 64'(rsp_valid), 64'(0));

        // Backpressure with both requesters valid the whole time.
        do_reset();
        set_req(0, 32'd10, 32'd3, 5'd1);
        set_req(1, 32'd99, 32'd1, 5'd0);
        run_op(2'b11, 5, g);
        check("bp_owner", 64'(g), 64'(0));

        // Continuous contention grant order.
        do_reset();
        set_req(0, 32'd1, 32'd2, 5'd0);
        set_req(1, 32'd3, 32'd4, 5'd1);
        for (int i = 0; i < NOrd; i++) begin
            run_op(2'b11, 0, g);
            check("contend_order", 64'(g), 64'(exp_order[i]));
        end

        // Reset while executing abandons the op.
        set_req(0, 32'd20, 32'd22, 5'd2);
        req_valid = 2'b01;
        #1;
        check("mid_grant", 64'(req_ready), 64'(2'b01));
        @(negedge clk);
        check("mid_alu_op", 64'(alu_op), 64'(2));
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_alu_op", 64'(alu_op), 64'(0));
        rst        = 1'b0;
        last_grant = 1;
        streak     = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_rsp", 64'(rsp_valid), 64'(0));
        end
        rsp_ready = 2'b00;
        set_req(1, 32'd40, 32'd2, 5'd0);
        run_op(2'b10, 0, g);
        check("mid_next_owner", 64'(g), 64'(1));

        // Random traffic.
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 2; k++) begin
                logic [4:0] op;
                case ($urandom_range(0, 3))
                    0:       op = 5'd0;
                    1:       op = 5'd1;
                    2:       op = 5'b11100;
                    default: op = 5'($urandom_range(0, 31));
                endcase
                set_req(k, $urandom, $urandom, op);
            end
            run_op(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: max consecutive requester-0 grants while requester 1 waits; used only when ALU_ARB_RR_EN is undefined.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  2  bit k: requester k presents an operation.
REQ-005 SHALL have port req_ready_o  output  2  bit k: arbiter accepts requester k this cycle.
REQ-006 SHALL have port req_a_i  input  64  operand A, requester k in bits [32k+31:32k].
REQ-007 SHALL have port req_b_i  input  64  operand B, same packing.
REQ-008 SHALL have port req_op_i  input  10  ALU opcode, requester k in bits [5k+4:5k].
REQ-009 SHALL have port rsp_valid_o  output  2  bit k: response for requester k available.
REQ-010 SHALL have port rsp_ready_i  input  2  bit k: requester k takes its response.
REQ-011 SHALL have port rsp_result_o  output  32  result of the completed operation, shared by both requesters.
REQ-012 SHALL have port rsp_flag_o  output  1  comparison flag of the completed operation, shared.
REQ-013 SHALL have ports alu_a_o, alu_b_o  output  32 each  operands to the shared ALU.
REQ-014 SHALL have port alu_op_o  output  5  opcode to the shared ALU.
REQ-015 SHALL have ports alu_result_i  input  32 and alu_flag_i  input  1  combinational ALU outputs.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-017 IDLE: req_ready_o SHALL be one-hot on the granted requester if any req_valid_i bit is set, else 2'b00; all other states drive 2'b00.
REQ-018 On valid&ready for requester k, SHALL latch its A, B, op and owner k, then go to EXEC.
REQ-019 alu_a_o/alu_b_o/alu_op_o SHALL always be driven from the latched operand registers; they hold their values outside EXEC.
REQ-020 EXEC: SHALL capture alu_result_i/alu_flag_i into the response registers, then go to RESP (exactly one cycle).
REQ-021 RESP: rsp_valid_o SHALL equal the one-hot of owner; the other bit SHALL be 0; result/flag stable until the handshake.
REQ-022 On rsp_valid_o[owner]&rsp_ready_i[owner], SHALL go to IDLE; no new acceptance in that same cycle.
REQ-023 Latency: acceptance at cycle N -> rsp_valid_o high from cycle N+2; minimum issue interval 3 cycles.
REQ-024 Dropping req_valid_i before acceptance SHALL have no effect; req_* inputs are ignored outside IDLE.
REQ-025 rsp_ready_i of the non-owner, and any rsp_ready_i outside RESP, SHALL be ignored.
REQ-026 Opcodes SHALL pass through unchecked; an undefined opcode yields whatever the ALU returns.
REQ-027 A single valid requester SHALL always be granted, in either arbitration mode.

Reset
REQ-028 With rst_i high at an edge: state IDLE, operand registers 0 (alu_op_o = 0, ALU_ADD), response registers 0, owner 0, RR pointer 1, burst counter 0.
REQ-029 During and after reset, req_ready_o and rsp_valid_o SHALL be 2'b00 until IDLE grant logic applies next cycle.
REQ-030 Reset in EXEC or RESP SHALL abandon the operation; no response is ever issued for it.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined: round-robin; when both valid, grant the requester not granted last; pointer updates on each acceptance; after reset requester 0 wins first.
REQ-032 ALU_ARB_RR_EN undefined: fixed priority to requester 0; a counter increments on each req0 grant made while req_valid_i[1]=1; when counter = MAX_BURST and req1 valid, grant req1; counter clears on a req1 grant or a req0 grant with req1 idle.

Verification
REQ-033 Single op: req0 A=7, B=5, op=5'b00000 (ADD), rsp_ready_i=2'b01 -> rsp_valid_o=2'b01 two cycles after acceptance, rsp_result_o=12, rsp_flag_o=0.
REQ-034 Compare: req1 A=0xFFFFFFFF, B=1, op=5'b11100 (LTS) -> rsp_valid_o=2'b10, rsp_flag_o=1, rsp_result_o=0.
REQ-035 Backpressure: req0 SUB 10-3, rsp_ready_i=0 for 5 cycles -> rsp_valid_o=2'b01, rsp_result_o=7 held stable; req_ready_o=0 throughout; both requesters valid meanwhile -> no acceptance.
REQ-036 Contention, RR build: both valid continuously, 4 ops -> grant order 0,1,0,1; no fixed-priority build: MAX_BURST=4 -> order 0,0,0,0,1,0.
REQ-037 Reset mid-op: assert rst_i in EXEC -> next cycle rsp_valid_o=0, alu_op_o=0, no response; next op from req1 completes normally.
